// File: rtl/ddr_tempo_ctrl_if.sv
// Control/status bundle for ddr_tempo_ctrl.
//   i_start/i_pause/i_stop : run-control pulses
//   i_level/i_level_req    : difficulty request (value + load pulse)
//   o_level_ack/o_level    : level applied pulse / active level
//   o_pix_en/o_seg_tick    : free-running clock-enable strobes
//   o_mov_tick/o_beat_cnt  : movement strobe / beats since fresh start
//   o_running              : high while in RUN
// slave = the scheduler, master = whoever drives the controls.
interface ddr_tempo_ctrl_if;
  logic        i_start;
  logic        i_pause;
  logic        i_stop;
  logic [1:0]  i_level;
  logic        i_level_req;
  logic        o_level_ack;
  logic [1:0]  o_level;
  logic        o_pix_en;
  logic        o_seg_tick;
  logic        o_mov_tick;
  logic [15:0] o_beat_cnt;
  logic        o_running;

  modport slave (
    input  i_start, i_pause, i_stop, i_level, i_level_req,
    output o_level_ack, o_level, o_pix_en, o_seg_tick, o_mov_tick,
           o_beat_cnt, o_running
  );

  modport master (
    output i_start, i_pause, i_stop, i_level, i_level_req,
    input  o_level_ack, o_level, o_pix_en, o_seg_tick, o_mov_tick,
           o_beat_cnt, o_running
  );
endinterface

// File: rtl/ddr_tempo_ctrl.sv
// Tempo and tick scheduler for the DDR game. Generates single-cycle
// clock-enable strobes in the i_clk domain: pixel enable, seven-segment
// refresh tick and a difficulty-scaled movement tick gated by an
// IDLE/RUN/PAUSE state machine.
// Ports:
//   i_clk   : system clock (only clock)
//   i_rst_n : asynchronous active-low reset
//   io_ctl  : ddr_tempo_ctrl_if.slave control/status bundle
// Parameters:
//   PIX_DIV  : pixel-enable period in cycles
//   SEG_DIV  : seven-segment tick period in cycles
//   MOV_BASE : movement period at level 0 (>= 8); level n uses MOV_BASE >> n
module ddr_tempo_ctrl #(
  parameter int unsigned PIX_DIV  = 4,
  parameter int unsigned SEG_DIV  = 10002,
  parameter int unsigned MOV_BASE = 625002
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  ddr_tempo_ctrl_if.slave io_ctl
);

  localparam int unsigned PIX_W = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
  localparam int unsigned SEG_W = (SEG_DIV > 1) ? $clog2(SEG_DIV) : 1;
  localparam logic [PIX_W-1:0] PIX_LAST = PIX_W'(PIX_DIV - 1);
  localparam logic [SEG_W-1:0] SEG_LAST = SEG_W'(SEG_DIV - 1);
  localparam logic [23:0]      MOV_P0   = 24'(MOV_BASE);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_PAUSE} state_t;

  // Free-running dividers
  logic [PIX_W-1:0] r_pix_cnt;
  logic [SEG_W-1:0] r_seg_cnt;
  logic             r_pix_en;
  logic             r_seg_tick;
  logic [PIX_W-1:0] w_pix_nxt;
  logic [SEG_W-1:0] w_seg_nxt;

  assign w_pix_nxt = (r_pix_cnt == PIX_LAST) ? '0 : r_pix_cnt + 1'b1;
  assign w_seg_nxt = (r_seg_cnt == SEG_LAST) ? '0 : r_seg_cnt + 1'b1;

  // Strobes are registered from the next count so each one is high
  // exactly while its counter holds DIV-1.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pix_cnt  <= '0;
      r_seg_cnt  <= '0;
      r_pix_en   <= 1'b0;
      r_seg_tick <= 1'b0;
    end else begin
      r_pix_cnt  <= w_pix_nxt;
      r_seg_cnt  <= w_seg_nxt;
      r_pix_en   <= (w_pix_nxt == PIX_LAST);
      r_seg_tick <= (w_seg_nxt == SEG_LAST);
    end
  end

  // Movement scheduler
  state_t      r_state;
  logic [23:0] r_mov_cnt;
  logic [23:0] r_period;
  logic [15:0] r_beat_cnt;
  logic [1:0]  r_level;
  logic [1:0]  r_pend_level;
  logic        r_pend_vld;
  logic        r_mov_tick;
  logic        r_level_ack;
  logic        r_running;

  logic        w_due;
  logic        w_apply;
  logic [23:0] w_period_nxt;

  // r_period latches the length of the period in progress, so a level
  // applied while paused only shapes the periods that start afterwards.
  assign w_due        = (r_state == ST_RUN) && (r_mov_cnt == r_period - 24'd1);
  assign w_apply      = r_pend_vld &&
                        ((r_state != ST_RUN) || (w_due && !io_ctl.i_stop));
  assign w_period_nxt = MOV_P0 >> (w_apply ? r_pend_level : r_level);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= ST_IDLE;
      r_mov_cnt    <= '0;
      r_period     <= '0;
      r_beat_cnt   <= '0;
      r_level      <= '0;
      r_pend_level <= '0;
      r_pend_vld   <= 1'b0;
      r_mov_tick   <= 1'b0;
      r_level_ack  <= 1'b0;
      r_running    <= 1'b0;
    end else begin
      r_mov_tick  <= 1'b0;
      r_level_ack <= 1'b0;

      if (w_apply) begin
        r_level     <= r_pend_level;
        r_level_ack <= 1'b1;
      end
      // A request on the applying edge becomes the next pending value.
      if (io_ctl.i_level_req) begin
        r_pend_level <= io_ctl.i_level;
        r_pend_vld   <= 1'b1;
      end else if (w_apply) begin
        r_pend_vld <= 1'b0;
      end

      if (io_ctl.i_stop) begin
        r_state    <= ST_IDLE;
        r_running  <= 1'b0;
        r_mov_cnt  <= '0;
        r_beat_cnt <= '0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (io_ctl.i_start) begin
              r_state    <= ST_RUN;
              r_running  <= 1'b1;
              r_mov_cnt  <= '0;
              r_beat_cnt <= '0;
              r_period   <= w_period_nxt;
            end
          end
          ST_RUN: begin
            // A tick due on the pause edge still fires and wraps.
            if (w_due) begin
              r_mov_tick <= 1'b1;
              r_mov_cnt  <= '0;
              r_beat_cnt <= r_beat_cnt + 16'd1;
              r_period   <= w_period_nxt;
            end else if (!io_ctl.i_pause) begin
              r_mov_cnt <= r_mov_cnt + 24'd1;
            end
            if (io_ctl.i_pause) begin
              r_state   <= ST_PAUSE;
              r_running <= 1'b0;
            end
          end
          ST_PAUSE: begin
            if (io_ctl.i_start) begin
              r_state   <= ST_RUN;
              r_running <= 1'b1;
            end
          end
          default: begin
            r_state   <= ST_IDLE;
            r_running <= 1'b0;
          end
        endcase
      end
    end
  end

  assign io_ctl.o_pix_en    = r_pix_en;
  assign io_ctl.o_seg_tick  = r_seg_tick;
  assign io_ctl.o_mov_tick  = r_mov_tick;
  assign io_ctl.o_beat_cnt  = r_beat_cnt;
  assign io_ctl.o_level     = r_level;
  assign io_ctl.o_level_ack = r_level_ack;
  assign io_ctl.o_running   = r_running;

endmodule

// File: tb/tb_ddr_tempo_ctrl.sv
// Bench for ddr_tempo_ctrl: directed scenarios with literal expectations,
// then randomized control traffic, all checked every cycle against a
// countdown-based behavioural model.
module tb_ddr_tempo_ctrl;
  localparam int unsigned PIX_DIV  = 4;
  localparam int unsigned SEG_DIV  = 5;
  localparam int unsigned MOV_BASE = 16;

  logic clk;
  logic rst_n;
  ddr_tempo_ctrl_if bus();

  ddr_tempo_ctrl #(
    .PIX_DIV (PIX_DIV),
    .SEG_DIV (SEG_DIV),
    .MOV_BASE(MOV_BASE)
  ) dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .io_ctl (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  bit          cmp_en   = 1'b0;

  task automatic chk(input string name, input int unsigned act, input int unsigned exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // m_rem = clock edges left until the next movement tick.
  int unsigned m_edges;
  int          m_mode;   // 0 idle, 1 run, 2 pause
  int unsigned m_rem;
  logic [15:0] m_beat;
  logic [1:0]  m_level;
  logic [1:0]  m_pend;
  bit          m_pend_v;
  bit          e_pix, e_seg, e_tick, e_ack;
  bit          mt_tick, mt_apply;
  logic [1:0]  mt_lvl;

  function automatic int unsigned period_of(input logic [1:0] lvl);
    return MOV_BASE >> lvl;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_edges = 0; m_mode = 0; m_rem = 0; m_beat = '0;
      m_level = '0; m_pend = '0; m_pend_v = 1'b0;
      e_pix = 0; e_seg = 0; e_tick = 0; e_ack = 0;
    end else begin
      m_edges++;
      e_pix = ((m_edges % PIX_DIV) == PIX_DIV - 1);
      e_seg = ((m_edges % SEG_DIV) == SEG_DIV - 1);
      mt_tick  = (m_mode == 1) && !bus.i_stop && (m_rem == 1);
      mt_apply = m_pend_v && ((m_mode != 1) || mt_tick);
      mt_lvl   = mt_apply ? m_pend : m_level;
      e_tick = 0;
      e_ack  = mt_apply;
      if (bus.i_stop) begin
        m_mode = 0; m_beat = '0; m_rem = 0;
      end else if (m_mode == 1) begin
        if (mt_tick) begin
          e_tick = 1; m_beat = m_beat + 16'd1; m_rem = period_of(mt_lvl);
        end else if (!bus.i_pause) begin
          m_rem = m_rem - 1;
        end
        if (bus.i_pause) m_mode = 2;
      end else if (bus.i_start) begin
        if (m_mode == 0) begin
          m_beat = '0; m_rem = period_of(mt_lvl);
        end
        m_mode = 1;
      end
      m_level = mt_lvl;
      if (bus.i_level_req) begin
        m_pend = bus.i_level; m_pend_v = 1'b1;
      end else if (mt_apply) begin
        m_pend_v = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("pix_en",    bus.o_pix_en,    e_pix);
      chk("seg_tick",  bus.o_seg_tick,  e_seg);
      chk("mov_tick",  bus.o_mov_tick,  e_tick);
      chk("level_ack", bus.o_level_ack, e_ack);
      chk("level",     bus.o_level,     m_level);
      chk("beat_cnt",  bus.o_beat_cnt,  m_beat);
      chk("running",   bus.o_running,   (m_mode == 1) ? 1 : 0);
    end
  end

  // ---------------- directed helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic count_to_tick(output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!bus.o_mov_tick && n < 200);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_pix"},     bus.o_pix_en,    0);
    chk({tag, "_seg"},     bus.o_seg_tick,  0);
    chk({tag, "_tick"},    bus.o_mov_tick,  0);
    chk({tag, "_ack"},     bus.o_level_ack, 0);
    chk({tag, "_level"},   bus.o_level,     0);
    chk({tag, "_beat"},    bus.o_beat_cnt,  0);
    chk({tag, "_running"}, bus.o_running,   0);
  endtask

  task automatic first_strobes(output int np, output int ns);
    np = 0; ns = 0;
    for (int i = 1; i <= 12; i++) begin
      step();
      if (bus.o_pix_en   && np == 0) np = i;
      if (bus.o_seg_tick && ns == 0) ns = i;
    end
  endtask

  int n, np, ns, cnt;

  initial begin
    rst_n = 1'b0;
    bus.i_start = 0; bus.i_pause = 0; bus.i_stop = 0;
    bus.i_level = 0; bus.i_level_req = 0;
    #1 cmp_en = 1'b1;

    // Reset held for 3 cycles, then released
    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("reset");
    rst_n = 1'b1;
    first_strobes(np, ns);
    chk("first_pix_edge", np, 3);
    chk("first_seg_edge", ns, 4);
    cnt = 0;
    repeat (100) begin step(); if (bus.o_mov_tick) cnt++; end
    chk("idle_ticks", cnt, 0);

    // Start: ticks at 16, 32, 48 edges
    bus.i_start = 1; step(); bus.i_start = 0;
    chk("running_after_start", bus.o_running, 1);
    for (int t = 0; t < 3; t++) begin
      count_to_tick(n);
      chk("tick_period_l0", n, 16);
    end
    chk("beat_after_3", bus.o_beat_cnt, 3);

    // Pause at mov_cnt=9, idle 50 cycles, resume: 7 cycles to next tick
    repeat (9) step();
    bus.i_pause = 1; step(); bus.i_pause = 0;
    cnt = 0;
    repeat (50) begin step(); if (bus.o_mov_tick) cnt++; end
    chk("paused_ticks", cnt, 0);
    chk("paused_beat", bus.o_beat_cnt, 3);
    bus.i_start = 1; step(); bus.i_start = 0;
    count_to_tick(n);
    chk("resume_to_tick", n, 7);
    chk("beat_after_resume", bus.o_beat_cnt, 4);
    chk("model_beat", m_beat, 4);

    // Level 2 request at mov_cnt=5: current period stays 16
    repeat (5) step();
    bus.i_level = 2; bus.i_level_req = 1; step(); bus.i_level_req = 0;
    count_to_tick(n);
    chk("req_to_tick", n, 10);
    chk("ack_with_tick", bus.o_level_ack, 1);
    chk("level_is_2", bus.o_level, 2);
    chk("model_level", m_level, 2);
    count_to_tick(n);
    chk("tick_period_l2", n, 4);

    // Simultaneous controls
    bus.i_stop = 1; bus.i_start = 1; step(); bus.i_stop = 0; bus.i_start = 0;
    chk("stop_start_run", bus.o_running, 0);
    chk("stop_start_beat", bus.o_beat_cnt, 0);
    bus.i_start = 1; step(); bus.i_start = 0;
    chk("restart_run", bus.o_running, 1);
    bus.i_pause = 1; bus.i_start = 1; step(); bus.i_pause = 0; bus.i_start = 0;
    chk("pause_start_run", bus.o_running, 0);
    bus.i_start = 1; step(); bus.i_start = 0;
    chk("resume_run", bus.o_running, 1);

    // Level 3, then async reset mid-RUN with a pending request
    bus.i_level = 3; bus.i_level_req = 1; step(); bus.i_level_req = 0;
    count_to_tick(n);
    chk("level_is_3", bus.o_level, 3);
    count_to_tick(n);
    chk("tick_period_l3", n, 2);
    bus.i_level = 1; bus.i_level_req = 1; step(); bus.i_level_req = 0;
    #2 rst_n = 1'b0;
    #1 chk_all_zero("async_rst");
    @(posedge clk); #1;
    rst_n = 1'b1;
    first_strobes(np, ns);
    chk("rst_pix_edge", np, 3);
    chk("rst_seg_edge", ns, 4);
    chk("pending_dropped", bus.o_level, 0);

    // Randomized control traffic
    for (int i = 0; i < 3000; i++) begin
      bus.i_start     = ($urandom_range(0, 19) == 0);
      bus.i_pause     = ($urandom_range(0, 29) == 0);
      bus.i_stop      = ($urandom_range(0, 79) == 0);
      bus.i_level_req = ($urandom_range(0, 14) == 0);
      bus.i_level     = 2'($urandom_range(0, 3));
      step();
    end
    bus.i_start = 0; bus.i_pause = 0; bus.i_stop = 0; bus.i_level_req = 0;
    repeat (4) step();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
